// File: rtl/shop_pkg.sv
// Shared definitions for the shop front end: ASCII control codes, field sizes,
// assembler state encoding and the command keys used by the controller.
package shop_pkg;

   localparam int A_CHARS_DEFAULT = 7;
   localparam int U_BITS_DEFAULT  = 4;
   localparam int KEY_BITS        = A_CHARS_DEFAULT * 8;

   localparam logic [7:0] TERM_CR = 8'h0D;
   localparam logic [7:0] TERM_LF = 8'h0A;
   localparam logic [7:0] BS      = 8'h08;
   localparam logic [7:0] HASH    = 8'h23;

   typedef enum logic [1:0] {
      COLLECT,
      EMIT,
      DROP
   } state_t;

   // String literals narrower than the word are right-justified and zero-padded,
   // which is exactly the layout the assembler produces.
   localparam logic [KEY_BITS-1:0] KEY_LOGIN    = "Login";
   localparam logic [KEY_BITS-1:0] KEY_LOGOUT   = "Logout";
   localparam logic [KEY_BITS-1:0] KEY_ADD_ITEM = "AddItem";
   localparam logic [KEY_BITS-1:0] KEY_DEL_ITEM = "DelItem";
   localparam logic [KEY_BITS-1:0] KEY_BUY      = "Buy";

   function automatic logic is_term(input logic [7:0] c);
      return (c == TERM_CR) || (c == TERM_LF);
   endfunction

endpackage

// File: rtl/shop_hex_decode.sv
// Combinational ASCII hex digit decoder: 0-9, A-F, a-f to a 4-bit value.
module shop_hex_decode (
   input  logic [7:0] i_char,
   output logic [3:0] o_val,
   output logic       o_is_hex
);

   // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      o_val    = 4'h0;
      o_is_hex = 1'b0;
      if (i_char >= "0" && i_char <= "9") begin
         o_val    = 4'(i_char - 8'h30);
         o_is_hex = 1'b1;
      end else if (i_char >= "A" && i_char <= "F") begin
         o_val    = 4'(i_char - 8'h37);
         o_is_hex = 1'b1;
      end else if (i_char >= "a" && i_char <= "f") begin
         o_val    = 4'(i_char - 8'h57);
         o_is_hex = 1'b1;
      end
   end

endmodule

// File: rtl/shop_cmd_assembler.sv
// Byte-serial ASCII token assembler: builds right-justified command words,
// hands each one downstream with a one-cycle pulse and decodes "#h" quantities.
module shop_cmd_assembler
   import shop_pkg::*;
#(
   parameter int A_NUM_ASCII_CHARS = A_CHARS_DEFAULT,
   parameter int A_NUM_BITS        = A_NUM_ASCII_CHARS * 8,
   parameter int U_NUM_BITS        = U_BITS_DEFAULT
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [7:0]            i_byte,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic                  i_busy,
   output logic [A_NUM_BITS-1:0] o_a,
   output logic [U_NUM_BITS-1:0] o_u,
   output logic                  o_rdy,
   output logic                  o_err
);

   localparam int CNT_W = $clog2(A_NUM_ASCII_CHARS + 1);

   state_t                  state_q, state_d;
   logic [A_NUM_BITS-1:0]   acc_q,   acc_d;
   logic [CNT_W-1:0]        cnt_q,   cnt_d;
   logic [A_NUM_BITS-1:0]   a_q,     a_d;
   logic [U_NUM_BITS-1:0]   u_q,     u_d;
   logic                    err_q,   err_d;

   logic       accept;
   logic       byte_is_term;
   logic       byte_is_bs;
   logic [3:0] hex_val;
   logic       hex_ok;

   // The most recent character sits in the low byte; a "#h" token has '#' just above it.
   shop_hex_decode u_hex (
      .i_char   (acc_q[7:0]),
      .o_val    (hex_val),
      .o_is_hex (hex_ok)
   );

   assign o_ready      = (state_q != EMIT);
   assign accept       = i_valid && o_ready;
   assign byte_is_term = is_term(i_byte);
   assign byte_is_bs   = (i_byte == BS);

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      u_d     = u_q;
      err_d   = 1'b0;
      unique case (state_q)
         COLLECT: begin
            if (accept) begin
               if (byte_is_term) begin
                  if (cnt_q == '0) begin
                     // Empty token (e.g. LF after CR): nothing to deliver.
                  end else if (cnt_q == CNT_W'(2) && acc_q[15:8] == HASH && hex_ok) begin
                     u_d   = U_NUM_BITS'(hex_val);
                     acc_d = '0;
                     cnt_d = '0;
                  end else begin
                     a_d     = acc_q;
                     acc_d   = '0;
                     cnt_d   = '0;
                     state_d = EMIT;
                  end
               end else if (byte_is_bs) begin
                  if (cnt_q != '0) begin
                     acc_d = acc_q >> 8;
                     cnt_d = cnt_q - CNT_W'(1);
                  end
               end else if (cnt_q == CNT_W'(A_NUM_ASCII_CHARS)) begin
                  err_d   = 1'b1;
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = DROP;
               end else begin
                  acc_d = {acc_q[A_NUM_BITS-9:0], i_byte};
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         EMIT: begin
            if (!i_busy) state_d = COLLECT;
         end
         DROP: begin
            if (accept && byte_is_term) state_d = COLLECT;
         end
         default: state_d = COLLECT;
      endcase
   end

   // NOTE: state updates use <= so every flop samples the pre-edge values of the others.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= COLLECT;
         acc_q   <= '0;
         cnt_q   <= '0;
         a_q     <= '0;
         u_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         u_q     <= u_d;
         err_q   <= err_d;
      end
   end

   // o_rdy must land in the cycle right after TERM, so it is decoded from the EMIT state.
   assign o_rdy = (state_q == EMIT) && !i_busy;
   assign o_a   = a_q;
   assign o_u   = u_q;
   assign o_err = err_q;

endmodule

// File: tb/tb_shop_cmd_assembler.sv
// Directed self-checking bench for shop_cmd_assembler.
module tb_shop_cmd_assembler;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic [7:0]  i_byte = 8'h00;
   logic        i_valid = 1'b0;
   logic        i_busy = 1'b0;
   logic        o_ready;
   logic [55:0] o_a;
   logic [3:0]  o_u;
   logic        o_rdy;
   logic        o_err;

   int tests_run    = 0;
   int tests_failed = 0;

   shop_cmd_assembler dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_byte  (i_byte),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_busy  (i_busy),
      .o_a     (o_a),
      .o_u     (o_u),
      .o_rdy   (o_rdy),
      .o_err   (o_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Applies inputs for one cycle; outputs are sampled 1 time unit later, well before the edge.
   task automatic drive(input logic v, input logic [7:0] b, input logic busy);
      @(negedge i_clk);
      i_valid = v;
      i_byte  = b;
      i_busy  = busy;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 8'h00, 1'b0);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         drive(1'b1, s[i], 1'b0);
         check({"ready_", s}, {63'd0, o_ready}, 64'd1);
      end
   endtask

   initial begin
      // Reset
      i_reset = 1'b1;
      idle();
      idle();
      check("rst_a",     {8'd0, o_a},     64'd0);
      check("rst_u",     {60'd0, o_u},    64'd0);
      check("rst_rdy",   {63'd0, o_rdy},  64'd0);
      check("rst_err",   {63'd0, o_err},  64'd0);
      check("rst_ready", {63'd0, o_ready}, 64'd1);
      i_reset = 1'b0;

      // "Login" CR: pulse in the cycle after CR, o_ready low for just that cycle
      send_str("Login");
      drive(1'b1, 8'h0D, 1'b0);
      check("login_cr_rdy", {63'd0, o_rdy}, 64'd0);
      idle();
      check("login_rdy",   {63'd0, o_rdy},   64'd1);
      check("login_a",     {8'd0, o_a},      64'h0000_004C_6F67_696E);
      check("login_ready", {63'd0, o_ready}, 64'd0);
      idle();
      check("login_rdy_off", {63'd0, o_rdy},   64'd0);
      check("login_ready1",  {63'd0, o_ready}, 64'd1);
      check("login_a_hold",  {8'd0, o_a},      64'h0000_004C_6F67_696E);

      // "Adm" CR LF: one pulse, LF ignored
      send_str("Adm");
      drive(1'b1, 8'h0D, 1'b0);
      idle();
      check("adm_rdy", {63'd0, o_rdy}, 64'd1);
      check("adm_a",   {8'd0, o_a},    64'h0000_0000_4164_6D);
      drive(1'b1, 8'h0A, 1'b0);
      check("adm_lf_ready", {63'd0, o_ready}, 64'd1);
      idle();
      check("adm_lf_rdy", {63'd0, o_rdy}, 64'd0);
      idle();
      check("adm_lf_rdy2", {63'd0, o_rdy}, 64'd0);

      // Exactly seven characters is a legal full-width token
      send_str("AddItem");
      drive(1'b1, 8'h0D, 1'b0);
      idle();
      check("full_rdy", {63'd0, o_rdy}, 64'd1);
      check("full_a",   {8'd0, o_a},    64'h0041_6464_4974_656D);
      check("full_err", {63'd0, o_err}, 64'd0);

      // Eight characters overflows: o_err once, no o_rdy, rest dropped until TERM
      send_str("AddItemX");
      idle();
      check("ovf_err",  {63'd0, o_err}, 64'd1);
      check("ovf_rdy",  {63'd0, o_rdy}, 64'd0);
      idle();
      check("ovf_err_off", {63'd0, o_err}, 64'd0);
      send_str("zz");
      drive(1'b1, 8'h0D, 1'b0);
      idle();
      check("drop_term_rdy", {63'd0, o_rdy}, 64'd0);
      check("drop_a_kept",   {8'd0, o_a},    64'h0041_6464_4974_656D);
      send_str("123");
      drive(1'b1, 8'h0D, 1'b0);
      idle();
      check("after_ovf_rdy", {63'd0, o_rdy}, 64'd1);
      check("after_ovf_a",   {8'd0, o_a},    64'h0000_0000_3132_33);

      // Backspace mid-token, and backspace on an empty token
      drive(1'b1, 8'h08, 1'b0);
      send_str("Us");
      drive(1'b1, 8'h08, 1'b0);
      send_str("b1");
      drive(1'b1, 8'h0D, 1'b0);
      idle();
      check("bs_rdy", {63'd0, o_rdy}, 64'd1);
      check("bs_a",   {8'd0, o_a},    64'h0000_0000_5562_31);

      // "#C" sets o_u without a pulse; "#G" is an ordinary token
      send_str("#C");
      drive(1'b1, 8'h0D, 1'b0);
      idle();
      check("hexC_rdy", {63'd0, o_rdy}, 64'd0);
      check("hexC_u",   {60'd0, o_u},   64'hC);
      send_str("#G");
      drive(1'b1, 8'h0D, 1'b0);
      idle();
      check("hexG_rdy", {63'd0, o_rdy}, 64'd1);
      check("hexG_a",   {8'd0, o_a},    64'h2347);
      check("hexG_u",   {60'd0, o_u},   64'hC);
      send_str("#a");
      drive(1'b1, 8'h0D, 1'b0);
      idle();
      check("hexa_u",   {60'd0, o_u},   64'hA);
      check("hexa_rdy", {63'd0, o_rdy}, 64'd0);

      // "Buy" with downstream busy for three cycles
      send_str("Buy");
      drive(1'b1, 8'h0D, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 8'h00, 1'b1);
         check("busy_ready", {63'd0, o_ready}, 64'd0);
         check("busy_rdy",   {63'd0, o_rdy},   64'd0);
         check("busy_a",     {8'd0, o_a},      64'h0000_0000_4275_79);
      end
      idle();
      check("busy_release_rdy", {63'd0, o_rdy}, 64'd1);
      check("busy_release_a",   {8'd0, o_a},    64'h0000_0000_4275_79);
      idle();
      check("busy_after_rdy", {63'd0, o_rdy}, 64'd0);

      // Reset mid-token discards "Del"
      send_str("Del");
      i_reset = 1'b1;
      idle();
      i_reset = 1'b0;
      idle();
      check("midrst_a",   {8'd0, o_a},   64'd0);
      check("midrst_u",   {60'd0, o_u},  64'd0);
      send_str("Logout");
      drive(1'b1, 8'h0D, 1'b0);
      idle();
      check("logout_rdy", {63'd0, o_rdy}, 64'd1);
      check("logout_a",   {8'd0, o_a},    64'h004C_6F67_6F75_74);
      check("logout_err", {63'd0, o_err}, 64'd0);
      idle();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/shop_cmd_assembler.md
Name: shop_cmd_assembler

Overview:
- Upstream front end for the shop controller.
- Takes a byte-serial ASCII stream (UART receiver or keyboard bridge) and assembles each terminator-delimited token into the fixed-width, right-justified, zero-padded ASCII word the controller expects on its command/data input.
- Delivers each token with a single-cycle ready pulse.
- Also decodes "#h" tokens into the 4-bit user/quantity field.

Parameters:
- A_NUM_ASCII_CHARS, 7, max token length in characters; must fit the longest command key ("AddItem", "DelItem").
- A_NUM_BITS, A_NUM_ASCII_CHARS*8, width of the assembled word.
- U_NUM_BITS, 4, width of the numeric field (max 15).

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_byte  in  8  incoming ASCII character.
- i_valid  in  1  i_byte is valid this cycle.
- o_ready  out  1  block accepts i_byte this cycle; a byte transfers when i_valid and o_ready are both high.
- i_busy  in  1  downstream cannot take a token this cycle.
- o_a  out  A_NUM_BITS  assembled token, right-justified, upper bytes 0x00.
- o_u  out  U_NUM_BITS  last decoded numeric field.
- o_rdy  out  1  one-cycle pulse; o_a is valid in that cycle.
- o_err  out  1  one-cycle pulse on token overflow.

Behaviour:
- Reset values: o_a=0, o_u=0, o_rdy=0, o_err=0, o_ready=1, accumulator=0, count=0, state=COLLECT.
- Reset mid-token discards the partial token.
- Character classes:
  - TERM is 0x0D or 0x0A.
  - BS is 0x08.
  - Every other byte is DATA.
- State COLLECT, o_ready=1:
  - DATA with count<A_NUM_ASCII_CHARS: acc <= {acc[A_NUM_BITS-9:0], byte}, count+1.
  - DATA with count==A_NUM_ASCII_CHARS: o_err pulses next cycle, acc and count clear, go to DROP.
  - BS with count>0: acc <= acc>>8, count-1. BS with count==0 is ignored.
  - TERM with count==0 (empty token, e.g. the LF of a CRLF pair) is ignored and produces no pulse.
  - TERM with count==2 and first char '#' and second char a hex digit (0-9, A-F, a-f): o_u <= digit value, acc and count clear, no o_rdy, stay in COLLECT.
  - TERM, any other nonzero count: latch acc into the output holding register, clear acc and count, go to EMIT.
- State EMIT, o_ready=0:
  - If i_busy=0: o_rdy=1 for exactly one cycle with o_a = held token, then go to COLLECT.
  - If i_busy=1: hold in EMIT; o_a stays stable; o_rdy stays 0.
- State DROP, o_ready=1:
  - All non-TERM bytes are discarded.
  - TERM returns to COLLECT with no pulse.
- Outputs between tokens:
  - o_a keeps the last emitted token until the next emission, so downstream may sample it after o_rdy.
  - o_u keeps its value until the next valid "#h" token or reset.
- Latency: the TERM byte accepted in cycle N gives o_rdy in cycle N+1 when i_busy=0 at N+1. Minimum spacing between pulses is 2 cycles.
- Simultaneous events: i_valid while in EMIT is not accepted (o_ready=0) and the upstream must hold the byte. No byte is ever dropped silently, except in DROP and for an ignored BS/empty TERM.
- No arithmetic other than the count (width clog2(A_NUM_ASCII_CHARS+1)) and the hex digit decode; digit values wrap to the low U_NUM_BITS.

Decomposition:
- Shared package (shop_pkg) holds:
  - The ASCII constants TERM_CR, TERM_LF, BS, HASH.
  - The A_NUM_ASCII_CHARS and U_NUM_BITS defaults.
  - The state encoding {COLLECT, EMIT, DROP}.
  - The command key strings, so bench and controller share them.
- One natural sub-module, shop_hex_decode: combinational ASCII hex digit to 4-bit value plus is_hex flag. Everything else lives in a single FSM.

Test Plan:
- Bytes "L","o","g","i","n",0x0D with i_busy=0 -> one o_rdy pulse in the cycle after CR, o_a = 56'h00_00_4C_6F_67_69_6E ("Login"); o_ready low for exactly that cycle.
- "Adm",0x0D,0x0A -> a single pulse with o_a=56'h0000000041646D; the LF produces no pulse.
- "AddItemX",0x0D -> o_err pulses once after the 8th char, no o_rdy; a following "123",0x0D gives o_a=56'h00000000313233.
- "Us",0x08,"b1",0x0D -> o_a="Ub1" (56'h00000000556231).
- "#",0x43,0x0D -> o_u=4'hC, no o_rdy. "#G",0x0D -> o_a="#G" pulse, o_u still 4'hC.
- "Buy",0x0D with i_busy=1 for 3 cycles -> o_ready=0 and o_a held stable, o_rdy asserts in the first cycle i_busy=0. Separately, i_reset asserted after "Del" -> o_a=0, count cleared, and the next "Logout",0x0D emits "Logout" only.
